// File: rtl/cpu_status_reg.sv
// rtl/cpu_status_reg.sv - 6502 processor status register P with NMI/IRQ conditioning
//
// Purpose: holds P = {N,V,1,B,D,I,Z,C}; captures ALU/BIT flags, flag set/clear
// instructions, pulled values (PLP/RTI) and interrupt entry; conditions the
// external NMI (falling-edge latch) and IRQ (level, masked by I) lines.
//
// Ports:
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   alu_out, carry_out,
//   overflow             ALU result and flags
//   ld_nz, ld_c, ld_v    independent ALU flag loads
//   bit_op               BIT: N,V from data_in[7:6], Z from alu_out
//   data_in              memory operand / pulled status byte
//   p_load               load P from data_in (PLP/RTI)
//   flag_op              0 none,1 CLC,2 SEC,3 CLI,4 SEI,5 CLD,6 SED,7 CLV
//   b_push               B bit for the pushed copy
//   int_ack              interrupt/BRK entry: force I=1
//   nmi_ack              sequencer took the NMI
//   nmi_n, irq_n         asynchronous active-low interrupt lines
//   p_out                registered status {N,V,1,0,D,I,Z,C}
//   p_push               pushed status {N,V,1,b_push,D,I,Z,C}
//   carry_flag           C to ALU carry_in
//   nmi_pending          latched NMI request
//   irq_pending          IRQ request masked by I

module cpu_status_reg #(
   parameter logic [7:0] RESET_P     = 8'h24,
   parameter int         SYNC_STAGES = 2      // legal 2..3
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] alu_out,
   input  logic       carry_out,
   input  logic       overflow,
   input  logic       ld_nz,
   input  logic       ld_c,
   input  logic       ld_v,
   input  logic       bit_op,
   input  logic [7:0] data_in,
   input  logic       p_load,
   input  logic [2:0] flag_op,
   input  logic       b_push,
   input  logic       int_ack,
   input  logic       nmi_ack,
   input  logic       nmi_n,
   input  logic       irq_n,
   output logic [7:0] p_out,
   output logic [7:0] p_push,
   output logic       carry_flag,
   output logic       nmi_pending,
   output logic       irq_pending
);

   localparam logic [2:0] OP_CLC = 3'd1;
   localparam logic [2:0] OP_SEC = 3'd2;
   localparam logic [2:0] OP_CLI = 3'd3;
   localparam logic [2:0] OP_SEI = 3'd4;
   localparam logic [2:0] OP_CLD = 3'd5;
   localparam logic [2:0] OP_SED = 3'd6;
   localparam logic [2:0] OP_CLV = 3'd7;

   logic flag_n, flag_v, flag_d, flag_i, flag_z, flag_c;
   logic next_n, next_v, next_d, next_i, next_z, next_c;
   logic alu_zero;

   // Bits 5:4 of a pulled byte have no storage in P.
   logic unused_data_bits;
   assign unused_data_bits = &{1'b0, data_in[5:4]};

   assign alu_zero = (alu_out == 8'h00);

   // Later stages override earlier ones: ALU/BIT, flag_op, p_load, int_ack.
   always_comb begin
      next_n = flag_n;
      next_v = flag_v;
      next_d = flag_d;
      next_i = flag_i;
      next_z = flag_z;
      next_c = flag_c;

      if (ld_nz) begin
         next_n = alu_out[7];
         next_z = alu_zero;
      end
      if (ld_v) begin
         next_v = overflow;
      end
      if (ld_c) begin
         next_c = carry_out;
      end
      if (bit_op) begin
         next_n = data_in[7];
         next_v = data_in[6];
         next_z = alu_zero;
      end

      case (flag_op)
         OP_CLC:  next_c = 1'b0;
         OP_SEC:  next_c = 1'b1;
         OP_CLI:  next_i = 1'b0;
         OP_SEI:  next_i = 1'b1;
         OP_CLD:  next_d = 1'b0;
         OP_SED:  next_d = 1'b1;
         OP_CLV:  next_v = 1'b0;
         default: ;
      endcase

      if (p_load) begin
         next_n = data_in[7];
         next_v = data_in[6];
         next_d = data_in[3];
         next_i = data_in[2];
         next_z = data_in[1];
         next_c = data_in[0];
      end

      if (int_ack) begin
         next_i = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         flag_n <= RESET_P[7];
         flag_v <= RESET_P[6];
         flag_d <= RESET_P[3];
         flag_i <= RESET_P[2];
         flag_z <= RESET_P[1];
         flag_c <= RESET_P[0];
      end else begin
         flag_n <= next_n;
         flag_v <= next_v;
         flag_d <= next_d;
         flag_i <= next_i;
         flag_z <= next_z;
         flag_c <= next_c;
      end
   end

   // D is kept for PHP/PLP fidelity only; the 2A03 ALU ignores it.
   assign p_out      = {flag_n, flag_v, 1'b1, 1'b0,   flag_d, flag_i, flag_z, flag_c};
   assign p_push     = {flag_n, flag_v, 1'b1, b_push, flag_d, flag_i, flag_z, flag_c};
   assign carry_flag = flag_c;

   // Interrupt line conditioning. Synchronisers reset to the inactive level so
   // a line already low at reset release still produces an NMI edge.
   logic [SYNC_STAGES-1:0] nmi_sync;
   logic [SYNC_STAGES-1:0] irq_sync;
   logic                   nmi_s, nmi_d, irq_s, nmi_edge;

   assign nmi_s    = nmi_sync[SYNC_STAGES-1];
   assign irq_s    = irq_sync[SYNC_STAGES-1];
   assign nmi_edge = nmi_d & ~nmi_s;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         nmi_sync    <= '1;
         irq_sync    <= '1;
         nmi_d       <= 1'b1;
         nmi_pending <= 1'b0;
      end else begin
         nmi_sync <= {nmi_sync[SYNC_STAGES-2:0], nmi_n};
         irq_sync <= {irq_sync[SYNC_STAGES-2:0], irq_n};
         nmi_d    <= nmi_s;
         // A fresh edge beats an acknowledge in the same cycle.
         if (nmi_edge) begin
            nmi_pending <= 1'b1;
         end else if (nmi_ack) begin
            nmi_pending <= 1'b0;
         end
      end
   end

   assign irq_pending = ~irq_s & ~flag_i;

endmodule

// File: tb/tb_cpu_status_reg.sv
// tb/tb_cpu_status_reg.sv - self-checking bench for cpu_status_reg

module tb_cpu_status_reg;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] alu_out;
   logic       carry_out, overflow, ld_nz, ld_c, ld_v, bit_op;
   logic [7:0] data_in;
   logic       p_load;
   logic [2:0] flag_op;
   logic       b_push, int_ack, nmi_ack, nmi_n, irq_n;
   logic [7:0] p_out, p_push;
   logic       carry_flag, nmi_pending, irq_pending;

   int vectors = 0;
   int miscompares = 0;
   logic [7:0] m_p;   // reference status byte as seen on p_out

   cpu_status_reg #(.RESET_P(8'h24), .SYNC_STAGES(2)) dut (
      .clk(clk), .rst_n(rst_n), .alu_out(alu_out), .carry_out(carry_out),
      .overflow(overflow), .ld_nz(ld_nz), .ld_c(ld_c), .ld_v(ld_v),
      .bit_op(bit_op), .data_in(data_in), .p_load(p_load), .flag_op(flag_op),
      .b_push(b_push), .int_ack(int_ack), .nmi_ack(nmi_ack), .nmi_n(nmi_n),
      .irq_n(irq_n), .p_out(p_out), .p_push(p_push), .carry_flag(carry_flag),
      .nmi_pending(nmi_pending), .irq_pending(irq_pending)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_ctl();
      alu_out = 8'h00; carry_out = 0; overflow = 0;
      ld_nz = 0; ld_c = 0; ld_v = 0; bit_op = 0;
      data_in = 8'h00; p_load = 0; flag_op = 3'd0;
      b_push = 0; int_ack = 0; nmi_ack = 0;
   endtask

   // Reference model: status byte after one cycle, from the instruction-level rules.
   function automatic logic [7:0] ref_next(input logic [7:0] p);
      logic [7:0] r;
      int fop_bit [8];
      logic fop_val [8];
      fop_bit = '{-1, 0, 0, 2, 2, 3, 3, 6};
      fop_val = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      r = p;
      if (bit_op) begin
         r[7] = data_in[7];
         r[6] = data_in[6];
         r[1] = (alu_out == 0);
      end else begin
         if (ld_nz) begin r[7] = alu_out[7]; r[1] = (alu_out == 0); end
         if (ld_v) r[6] = overflow;
      end
      if (ld_c) r[0] = carry_out;
      if (flag_op != 0) r[fop_bit[flag_op]] = fop_val[flag_op];
      if (p_load) r = (data_in & 8'hCF) | 8'h20;
      if (int_ack) r[2] = 1'b1;
      return r;
   endfunction

   task automatic step_model();
      m_p = ref_next(m_p);
      tick();
   endtask

   task automatic do_reset();
      idle_ctl();
      nmi_n = 1; irq_n = 1;
      rst_n = 0;
      tick(); tick();
      rst_n = 1;
      m_p = 8'h24;
   endtask

   task automatic test_reset();
      idle_ctl();
      ld_c = 1; carry_out = 1; ld_nz = 1; alu_out = 8'h80;
      tick();
      #3;
      rst_n = 0;
      #1;
      vectors++;
      if (p_out !== 8'h24) begin miscompares++; $display("FAIL reset_p_out: got %h want 24", p_out); end
      vectors++;
      if (nmi_pending !== 1'b0 || irq_pending !== 1'b0 || carry_flag !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_flags: nmi=%b irq=%b c=%b want 0 0 0", nmi_pending, irq_pending, carry_flag);
      end
      tick();
      vectors++;
      if (p_out !== 8'h24) begin miscompares++; $display("FAIL reset_discard_update: got %h want 24", p_out); end
      rst_n = 1;
      idle_ctl();
      m_p = 8'h24;
   endtask

   task automatic test_alu_flags();
      alu_out = 8'h00; carry_out = 1; overflow = 1; ld_nz = 1; ld_c = 1; ld_v = 1;
      step_model();
      vectors++;
      if (p_out !== 8'h67 || m_p !== 8'h67) begin miscompares++; $display("FAIL alu_all: got %h want 67", p_out); end
      idle_ctl();
      alu_out = 8'h80; ld_nz = 1;
      step_model();
      vectors++;
      if (p_out !== 8'hE5) begin miscompares++; $display("FAIL alu_nz_only: got %h want e5", p_out); end
      idle_ctl();
   endtask

   task automatic test_priority();
      ld_c = 1; carry_out = 1; flag_op = 3'd1;
      step_model();
      vectors++;
      if (carry_flag !== 1'b0 || p_out !== m_p) begin
         miscompares++; $display("FAIL prio_clc: got %h want %h", p_out, m_p);
      end
      idle_ctl();
      p_load = 1; data_in = 8'hFF; int_ack = 1; flag_op = 3'd3;
      step_model();
      vectors++;
      if (p_out !== 8'hEF) begin miscompares++; $display("FAIL prio_pload_intack: got %h want ef", p_out); end
      idle_ctl();
      b_push = 1;
      #1;
      vectors++;
      if (p_push !== 8'hFF) begin miscompares++; $display("FAIL p_push_b1: got %h want ff", p_push); end
      b_push = 0;
      #1;
      vectors++;
      if (p_push !== 8'hEF) begin miscompares++; $display("FAIL p_push_b0: got %h want ef", p_push); end
   endtask

   task automatic test_bit();
      bit_op = 1; data_in = 8'hC0; alu_out = 8'h00; ld_nz = 1; ld_v = 1; overflow = 0;
      step_model();
      vectors++;
      if (p_out[7] !== 1 || p_out[6] !== 1 || p_out[1] !== 1 || p_out !== m_p) begin
         miscompares++; $display("FAIL bit_set: got %h want %h", p_out, m_p);
      end
      data_in = 8'h3F; alu_out = 8'h01; overflow = 1;
      step_model();
      vectors++;
      if (p_out[7] !== 0 || p_out[6] !== 0 || p_out[1] !== 0 || p_out !== m_p) begin
         miscompares++; $display("FAIL bit_clear: got %h want %h", p_out, m_p);
      end
      idle_ctl();
   endtask

   task automatic test_random();
      for (int k = 0; k < 300; k++) begin
         alu_out   = 8'($urandom);
         data_in   = 8'($urandom);
         carry_out = 1'($urandom);
         overflow  = 1'($urandom);
         ld_nz     = 1'($urandom);
         ld_c      = 1'($urandom);
         ld_v      = 1'($urandom);
         bit_op    = ($urandom_range(0, 3) == 0);
         p_load    = ($urandom_range(0, 7) == 0);
         int_ack   = ($urandom_range(0, 7) == 0);
         flag_op   = 3'($urandom);
         b_push    = 1'($urandom);
         step_model();
         vectors++;
         if (p_out !== m_p || carry_flag !== m_p[0] ||
             p_push !== ((m_p & 8'hEF) | (8'(b_push) << 4))) begin
            miscompares++;
            $display("FAIL random_%0d: p_out=%h p_push=%h c=%b want %h b=%b", k, p_out, p_push, carry_flag, m_p, b_push);
         end
      end
      idle_ctl();
   endtask

   task automatic test_nmi();
      int bad;
      nmi_n = 0;
      tick();
      tick();
      vectors++;
      if (nmi_pending !== 0) begin miscompares++; $display("FAIL nmi_early: got %b want 0", nmi_pending); end
      tick();
      vectors++;
      if (nmi_pending !== 1) begin miscompares++; $display("FAIL nmi_third_edge: got %b want 1", nmi_pending); end
      bad = 0;
      for (int k = 0; k < 7; k++) begin tick(); if (nmi_pending !== 1) bad++; end
      vectors++;
      if (bad != 0) begin miscompares++; $display("FAIL nmi_hold: %0d cycles low, want 0", bad); end
      nmi_ack = 1;
      tick();
      nmi_ack = 0;
      vectors++;
      if (nmi_pending !== 0) begin miscompares++; $display("FAIL nmi_ack_clear: got %b want 0", nmi_pending); end
      bad = 0;
      for (int k = 0; k < 5; k++) begin tick(); if (nmi_pending !== 0) bad++; end
      vectors++;
      if (bad != 0) begin miscompares++; $display("FAIL nmi_single_request: %0d cycles high, want 0", bad); end
      nmi_n = 1;
      repeat (4) tick();
      nmi_n = 0;
      repeat (3) tick();
      nmi_n = 1;
      repeat (4) tick();
      vectors++;
      if (nmi_pending !== 1) begin miscompares++; $display("FAIL nmi_second_edge: got %b want 1", nmi_pending); end
      nmi_n = 0;
      tick(); tick();
      nmi_ack = 1;   // sampled on the same edge that sees the new falling edge
      tick();
      nmi_ack = 0;
      vectors++;
      if (nmi_pending !== 1) begin miscompares++; $display("FAIL nmi_edge_beats_ack: got %b want 1", nmi_pending); end
      nmi_ack = 1;
      tick();
      nmi_ack = 0;
      vectors++;
      if (nmi_pending !== 0) begin miscompares++; $display("FAIL nmi_ack_after: got %b want 0", nmi_pending); end
      nmi_n = 1;
      repeat (3) tick();
   endtask

   task automatic test_irq();
      do_reset();
      irq_n = 0;
      repeat (3) tick();
      vectors++;
      if (irq_pending !== 0) begin miscompares++; $display("FAIL irq_masked: got %b want 0", irq_pending); end
      flag_op = 3'd3;
      tick();
      flag_op = 3'd0;
      vectors++;
      if (irq_pending !== 1) begin miscompares++; $display("FAIL irq_after_cli: got %b want 1", irq_pending); end
      int_ack = 1;
      tick();
      int_ack = 0;
      vectors++;
      if (irq_pending !== 0 || p_out[2] !== 1) begin
         miscompares++; $display("FAIL irq_int_ack: irq=%b i=%b want 0 1", irq_pending, p_out[2]);
      end
      flag_op = 3'd3;
      tick();
      flag_op = 3'd0;
      irq_n = 1;
      tick();
      vectors++;
      if (irq_pending !== 1) begin miscompares++; $display("FAIL irq_release_1: got %b want 1", irq_pending); end
      tick();
      vectors++;
      if (irq_pending !== 0) begin miscompares++; $display("FAIL irq_release_2: got %b want 0", irq_pending); end
   endtask

   initial begin
      do_reset();
      test_reset();
      test_alu_flags();
      test_priority();
      test_bit();
      test_random();
      test_nmi();
      test_irq();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/cpu_status_reg.md
Name: cpu_status_reg

Overview:
- Holds the 6502 processor status register P (N V - B D I Z C).
- Sits directly downstream of the ALU: captures the ALU result flags (result, carry_out, overflow) under control of the decoder.
- Feeds the C flag back to the ALU carry_in.
- Also owns interrupt-line conditioning: NMI falling-edge latch and level-sensitive IRQ gated by the I flag, for the sequencer.

Parameters:
- RESET_P, 8'h24, P value after reset (I=1, bit5=1, all other flags 0).
- SYNC_STAGES, 2, synchroniser depth for nmi_n/irq_n; legal values 2..3.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- alu_out  input  8  ALU result.
- carry_out  input  1  ALU carry.
- overflow  input  1  ALU overflow.
- ld_nz  input  1  load N=alu_out[7], Z=(alu_out==0).
- ld_c  input  1  load C=carry_out.
- ld_v  input  1  load V=overflow.
- bit_op  input  1  BIT instruction: N=data_in[7], V=data_in[6], Z=(alu_out==0).
- data_in  input  8  memory operand (BIT) / pulled value (PLP, RTI).
- p_load  input  1  load P from data_in (PLP/RTI).
- flag_op  input  3  0 none, 1 CLC, 2 SEC, 3 CLI, 4 SEI, 5 CLD, 6 SED, 7 CLV.
- b_push  input  1  B bit value for pushed copy (1 for BRK/PHP, 0 for IRQ/NMI).
- int_ack  input  1  sequencer entering interrupt/BRK vector fetch.
- nmi_ack  input  1  sequencer has taken the NMI.
- nmi_n  input  1  external NMI, asynchronous, active low.
- irq_n  input  1  external IRQ, asynchronous, active low.
- p_out  output  8  {N,V,1,0,D,I,Z,C}.
- p_push  output  8  {N,V,1,b_push,D,I,Z,C}, combinational.
- carry_flag  output  1  C, to ALU carry_in.
- nmi_pending  output  1  latched NMI request.
- irq_pending  output  1  IRQ request, masked by I.

Behaviour:
- Reset (rst_n low, asynchronous):
  - P = RESET_P, so p_out = 8'h24.
  - nmi_pending = 0.
  - All synchroniser flops = 1 (inactive); edge-history flop = 1.
  - Outputs hold these values until the first rising edge after rst_n rises.
  - Reset asserted mid-update discards the update.
- All P updates are registered: a control input sampled at edge k is visible on p_out after edge k.
- Update priority within one cycle (later item overrides earlier):
  1. ALU/BIT loads.
  2. flag_op.
  3. p_load.
  4. int_ack.
- ALU/BIT loads:
  - ld_nz, ld_c and ld_v are independent and may combine.
  - bit_op overrides ld_nz and ld_v for N, V and Z.
- flag_op: affects only the named bit and overrides an ALU load of the same bit.
- p_load: P = {data_in[7:6], 1, 0, data_in[3:0]}; data_in bits 5 and 4 are ignored.
- int_ack: forces I=1 and overrides CLI and p_load in the same cycle.
- D flag: stored and reported only; no effect on arithmetic (NES 2A03 has no decimal mode).
- p_out[5]=1 and p_out[4]=0 always; B exists only in p_push.
- carry_flag = P[0], combinational from the register.
- NMI path:
  - nmi_n passes through SYNC_STAGES flops to give nmi_s; a history flop nmi_d <= nmi_s.
  - Falling edge = nmi_d & ~nmi_s.
  - On an edge, nmi_pending is set on the next rising edge. With SYNC_STAGES=2, nmi_pending rises at the 3rd rising edge after nmi_n falls.
  - nmi_ack clears nmi_pending; a new edge in the same cycle wins (stays set).
  - Holding nmi_n low produces exactly one request. A pulse shorter than one clock period may be missed; nmi_n low for ≥1 period is guaranteed to be seen.
- IRQ path:
  - irq_n passes through SYNC_STAGES flops to give irq_s.
  - irq_pending = ~irq_s & ~P[2], combinational from registers. It is not latched: it drops when irq_n is released or I is set.
- int_ack does not touch nmi_pending; the sequencer drives nmi_ack explicitly.

Test Plan:
- Reset: assert rst_n=0 mid-cycle -> p_out=8'h24 immediately, nmi_pending=0, irq_pending=0, carry_flag=0.
- ALU flags:
  - alu_out=8'h00, carry_out=1, overflow=1, ld_nz=ld_c=ld_v=1 for one cycle -> next cycle p_out=8'h67.
  - Then alu_out=8'h80, ld_nz only -> p_out=8'hE5.
- Priority:
  - ld_c=1 with carry_out=1, same cycle flag_op=CLC -> C=0.
  - p_load with data_in=8'hFF plus int_ack -> p_out=8'hEF.
  - p_push with b_push=1 -> 8'hFF.
- BIT:
  - data_in=8'hC0, alu_out=8'h00, bit_op=1 -> N=1, V=1, Z=1.
  - Then data_in=8'h3F, alu_out=8'h01 -> N=0, V=0, Z=0.
- NMI:
  - Drop nmi_n and hold it low for 10 cycles -> nmi_pending rises after 3rd edge.
  - nmi_ack -> clears and stays 0 while nmi_n is still low.
  - Release, then re-drop nmi_n timed so its edge detect coincides with nmi_ack -> nmi_pending stays 1.
- IRQ:
  - With I=1 (after reset), irq_n=0 -> irq_pending=0.
  - flag_op=CLI -> irq_pending=1 the cycle after I clears.
  - int_ack -> I=1 and irq_pending=0.
  - Release irq_n with I=0 -> irq_pending falls 2 edges later.
